// File: rtl/vdu_timing_gen_if.sv
// Config port of the VDU timing generator: shadow-register writes and the pending flag.
interface vdu_timing_gen_if #(
  parameter int CORDW = 16
) ();
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [CORDW-1:0] cfg_wdata;
  logic             cfg_pending;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_pending);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_pending);
endinterface

// File: rtl/vdu_timing_gen.sv
// Runtime-programmable video timing generator: syncs, data enable, strobes and signed
// coordinates, with shadowed timing registers that switch atomically at the frame boundary.
module vdu_timing_gen #(
  parameter int CORDW    = 16,
  parameter int FCW      = 16,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int IRQ_LINE = 0
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  vdu_timing_gen_if.slave         cfg,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic                    irq,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [FCW-1:0]          frame_cnt
);

  typedef logic signed [CORDW-1:0] coord_t;

  typedef struct packed {
    coord_t     h_res;
    coord_t     h_fp;
    coord_t     h_sync;
    coord_t     h_bp;
    coord_t     v_res;
    coord_t     v_fp;
    coord_t     v_sync;
    coord_t     v_bp;
    logic [1:0] pol;       // {v_pol, h_pol}, 1 = active high
    coord_t     irq_line;
  } timing_t;

  localparam timing_t Init = '{
    h_res:    coord_t'(H_RES),
    h_fp:     coord_t'(H_FP),
    h_sync:   coord_t'(H_SYNC),
    h_bp:     coord_t'(H_BP),
    v_res:    coord_t'(V_RES),
    v_fp:     coord_t'(V_FP),
    v_sync:   coord_t'(V_SYNC),
    v_bp:     coord_t'(V_BP),
    pol:      {V_POL != 0, H_POL != 0},
    irq_line: coord_t'(IRQ_LINE)
  };
  localparam coord_t InitHSta = coord_t'(-(H_FP + H_SYNC + H_BP));
  localparam coord_t InitVSta = coord_t'(-(V_FP + V_SYNC + V_BP));

  timing_t shadow_q, shadow_d, active_q, active_d;
  coord_t  x_q, x_d, y_q, y_d;
  logic    pending_q, pending_d;
  coord_t  wdata;
  logic    cfg_valid, last_x, boundary;
  coord_t  h_sta, h_ss, h_se, v_sta, v_ss, v_se, new_h_sta, new_v_sta;
  logic    hsync_d, vsync_d, de_d, frame_d, line_d, irq_d;

  assign cfg.cfg_pending = pending_q;

  always_comb begin
    h_sta     = -(active_q.h_fp + active_q.h_sync + active_q.h_bp);
    h_ss      = h_sta + active_q.h_fp;
    h_se      = h_ss + active_q.h_sync;
    v_sta     = -(active_q.v_fp + active_q.v_sync + active_q.v_bp);
    v_ss      = v_sta + active_q.v_fp;
    v_se      = v_ss + active_q.v_sync;
    new_h_sta = -(shadow_q.h_fp + shadow_q.h_sync + shadow_q.h_bp);
    new_v_sta = -(shadow_q.v_fp + shadow_q.v_sync + shadow_q.v_bp);
  end

  // Shadow write decode; a zero resolution would stall the raster, so it is stored as 1.
  always_comb begin
    shadow_d  = shadow_q;
    wdata     = coord_t'(cfg.cfg_wdata);
    cfg_valid = cfg.cfg_we && (cfg.cfg_addr <= 4'd9);
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        4'd0:    shadow_d.h_res    = (wdata == '0) ? coord_t'(1) : wdata;
        4'd1:    shadow_d.h_fp     = wdata;
        4'd2:    shadow_d.h_sync   = wdata;
        4'd3:    shadow_d.h_bp     = wdata;
        4'd4:    shadow_d.v_res    = (wdata == '0) ? coord_t'(1) : wdata;
        4'd5:    shadow_d.v_fp     = wdata;
        4'd6:    shadow_d.v_sync   = wdata;
        4'd7:    shadow_d.v_bp     = wdata;
        4'd8:    shadow_d.pol      = cfg.cfg_wdata[1:0];
        4'd9:    shadow_d.irq_line = wdata;
        default: ;
      endcase
    end
  end

  // Raster counters; the boundary edge restarts on the incoming set's blanking start.
  always_comb begin
    last_x    = (x_q == active_q.h_res - coord_t'(1));
    boundary  = last_x && (y_q == active_q.v_res - coord_t'(1));
    x_d       = x_q + coord_t'(1);
    y_d       = y_q;
    active_d  = active_q;
    pending_d = pending_q | cfg_valid;
    if (boundary) begin
      x_d       = new_h_sta;
      y_d       = new_v_sta;
      active_d  = shadow_q;
      pending_d = cfg_valid;
    end else if (last_x) begin
      x_d = h_sta;
      y_d = y_q + coord_t'(1);
    end
  end

  always_comb begin
    de_d    = !x_q[CORDW-1] && !y_q[CORDW-1];
    hsync_d = ((x_q >= h_ss) && (x_q < h_se)) == active_q.pol[0];
    vsync_d = ((y_q >= v_ss) && (y_q < v_se)) == active_q.pol[1];
    frame_d = (x_q == h_sta) && (y_q == v_sta);
    line_d  = (x_q == h_sta) && !y_q[CORDW-1];
    irq_d   = (x_q == h_sta) && (y_q == active_q.irq_line);
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      shadow_q  <= Init;
      active_q  <= Init;
      x_q       <= InitHSta;
      y_q       <= InitVSta;
      pending_q <= 1'b0;
      sx        <= InitHSta;
      sy        <= InitVSta;
      hsync     <= !Init.pol[0];
      vsync     <= !Init.pol[1];
      de        <= 1'b0;
      frame     <= 1'b0;
      line      <= 1'b0;
      irq       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
      sx        <= x_q;
      sy        <= y_q;
      hsync     <= hsync_d;
      vsync     <= vsync_d;
      de        <= de_d;
      frame     <= frame_d;
      line      <= line_d;
      irq       <= irq_d;
      if (frame_d) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vdu_timing_gen.sv
// Bench for vdu_timing_gen: a 640x480 default instance and a small reprogrammable instance,
// both checked against a frame-position model of the raster.
module tb_vdu_timing_gen;
  localparam int CORDW = 16;
  localparam int FCW   = 16;

  typedef struct {
    int hres, hfp, hs, hbp, vres, vfp, vs, vbp, hpol, vpol, irq;
  } mode_t;

  typedef struct packed {
    logic hsync, vsync, de, frame, line, irq;
    logic signed [15:0] sx, sy;
  } vid_t;

  logic clk_pix = 1'b0;
  logic rst = 1'b1;
  always #5 clk_pix = ~clk_pix;

  vdu_timing_gen_if #(.CORDW(CORDW)) cfg0 ();
  vdu_timing_gen_if #(.CORDW(CORDW)) cfg1 ();

  logic hsync0, vsync0, de0, frame0, line0, irq0;
  logic hsync1, vsync1, de1, frame1, line1, irq1;
  logic signed [CORDW-1:0] sx0, sy0, sx1, sy1;
  logic [FCW-1:0] frame_cnt0, frame_cnt1;

  vdu_timing_gen dut0 (
    .clk_pix(clk_pix), .rst(rst), .cfg(cfg0),
    .hsync(hsync0), .vsync(vsync0), .de(de0), .frame(frame0), .line(line0), .irq(irq0),
    .sx(sx0), .sy(sy0), .frame_cnt(frame_cnt0)
  );

  vdu_timing_gen #(
    .H_RES(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_RES(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(0), .V_POL(1), .IRQ_LINE(3)
  ) dut1 (
    .clk_pix(clk_pix), .rst(rst), .cfg(cfg1),
    .hsync(hsync1), .vsync(vsync1), .de(de1), .frame(frame1), .line(line1), .irq(irq1),
    .sx(sx1), .sy(sy1), .frame_cnt(frame_cnt1)
  );

  vid_t obs0, obs1;
  assign obs0 = {hsync0, vsync0, de0, frame0, line0, irq0, sx0, sy0};
  assign obs1 = {hsync1, vsync1, de1, frame1, line1, irq1, sx1, sy1};

  mode_t def0, def1, act1, sh1;
  int    c0, c1, fc0, fc1;
  vid_t  exp0, exp1;
  logic  pend1;
  int    checks = 0;
  int    failures = 0;

  function automatic int line_len(mode_t m);
    return m.hres + m.hfp + m.hs + m.hbp;
  endfunction

  function automatic int frame_len(mode_t m);
    return line_len(m) * (m.vres + m.vfp + m.vs + m.vbp);
  endfunction

  // Outputs expected for raster position c (cycles since frame start) under mode m.
  function automatic vid_t predict(int c, mode_t m);
    vid_t v;
    int lp = line_len(m);
    int hb = m.hfp + m.hs + m.hbp;
    int vb = m.vfp + m.vs + m.vbp;
    int xs = c % lp - hb;
    int ys = c / lp - vb;
    v.sx    = 16'(xs);
    v.sy    = 16'(ys);
    v.de    = (xs >= 0) && (ys >= 0);
    v.hsync = ((xs >= m.hfp - hb) && (xs < m.hfp + m.hs - hb)) == (m.hpol != 0);
    v.vsync = ((ys >= m.vfp - vb) && (ys < m.vfp + m.vs - vb)) == (m.vpol != 0);
    v.frame = (c == 0);
    v.line  = (c % lp == 0) && (ys >= 0);
    v.irq   = (c % lp == 0) && (ys == m.irq);
    return v;
  endfunction

  function automatic vid_t reset_vid(mode_t m);
    vid_t v;
    v.sx    = 16'(-(m.hfp + m.hs + m.hbp));
    v.sy    = 16'(-(m.vfp + m.vs + m.vbp));
    v.hsync = (m.hpol == 0);
    v.vsync = (m.vpol == 0);
    v.de    = 1'b0;
    v.frame = 1'b0;
    v.line  = 1'b0;
    v.irq   = 1'b0;
    return v;
  endfunction

  task automatic reset_models();
    act1 = def1;
    sh1  = def1;
    c0   = 0;
    c1   = 0;
    fc0  = 0;
    fc1  = 0;
    pend1 = 1'b0;
    exp0 = reset_vid(def0);
    exp1 = reset_vid(def1);
  endtask

  task automatic shadow_write(input logic [3:0] a, input logic [15:0] d);
    case (a)
      4'd0: sh1.hres = (d == 0) ? 1 : int'(d);
      4'd1: sh1.hfp  = int'(d);
      4'd2: sh1.hs   = int'(d);
      4'd3: sh1.hbp  = int'(d);
      4'd4: sh1.vres = (d == 0) ? 1 : int'(d);
      4'd5: sh1.vfp  = int'(d);
      4'd6: sh1.vs   = int'(d);
      4'd7: sh1.vbp  = int'(d);
      4'd8: begin sh1.hpol = int'(d[0]); sh1.vpol = int'(d[1]); end
      4'd9: sh1.irq  = int'($signed(d));
      default: ;
    endcase
  endtask

  // One pixel clock with optional config write; advances the model to the new outputs.
  task automatic step(input logic we = 1'b0, input logic [3:0] a = 4'd0,
                      input logic [15:0] d = 16'd0);
    logic boundary, valid;
    cfg1.cfg_we    = we;
    cfg1.cfg_addr  = a;
    cfg1.cfg_wdata = d;
    @(posedge clk_pix);
    exp0 = predict(c0, def0);
    if (exp0.frame) fc0 = (fc0 + 1) & 16'hffff;
    c0 = (c0 + 1) % frame_len(def0);
    exp1 = predict(c1, act1);
    if (exp1.frame) fc1 = (fc1 + 1) & 16'hffff;
    boundary = (c1 == frame_len(act1) - 1);
    valid = we && (a <= 4'd9);
    if (boundary) begin
      act1  = sh1;
      c1    = 0;
      pend1 = valid;
    end else begin
      c1++;
      pend1 = pend1 | valid;
    end
    if (we) shadow_write(a, d);
    #1;
    cfg1.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    cfg1.cfg_we = 1'b0; cfg1.cfg_addr = '0; cfg1.cfg_wdata = '0;
    cfg0.cfg_we = 1'b0; cfg0.cfg_addr = '0; cfg0.cfg_wdata = '0;
    reset_models();
    #23;
    checks++;
    if (obs1 !== exp1 || frame_cnt1 !== 16'd0 || cfg1.cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_small: got %h fc=%0d pend=%b, want %h fc=0 pend=0",
               obs1, frame_cnt1, cfg1.cfg_pending, exp1);
    end
    checks++;
    if (obs0 !== exp0 || frame_cnt0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_default: got %h fc=%0d, want %h fc=0", obs0, frame_cnt0, exp0);
    end
    @(posedge clk_pix);
    #1 rst = 1'b0;
    step();
    checks++;
    if (frame0 !== 1'b1 || sx0 !== -16'sd160 || sy0 !== -16'sd45 || frame_cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL first_frame_default: frame=%b sx=%0d sy=%0d fc=%0d, want 1 -160 -45 1",
               frame0, sx0, sy0, frame_cnt0);
    end
    checks++;
    if (frame1 !== 1'b1 || sx1 !== -16'sd8 || sy1 !== -16'sd5 || frame_cnt1 !== 16'd1) begin
      failures++;
      $display("FAIL first_frame_small: frame=%b sx=%0d sy=%0d fc=%0d, want 1 -8 -5 1",
               frame1, sx1, sy1, frame_cnt1);
    end
  endtask

  task automatic test_default_mode();
    int wrap_at = -1, low_n = 0, low_first = 9999, low_last = -9999;
    // Step 1 (in test_reset) showed pixel 0; steps 2..1700 show pixels 1..1699.
    for (int k = 2; k <= 1700; k++) begin
      step();
      checks++;
      if (obs0 !== exp0 || frame_cnt0 !== 16'(fc0)) begin
        failures++;
        $display("FAIL default_raster k=%0d: got %h fc=%0d, want %h fc=%0d",
                 k, obs0, frame_cnt0, exp0, fc0);
      end
      if (sx0 == -16'sd160 && wrap_at < 0) wrap_at = k;
      if (k <= 800 && hsync0 == 1'b0) begin
        low_n++;
        if (int'(sx0) < low_first) low_first = int'(sx0);
        if (int'(sx0) > low_last) low_last = int'(sx0);
      end
    end
    checks++;
    if (wrap_at != 801) begin
      failures++;
      $display("FAIL default_line_period: got %0d, want 800", wrap_at - 1);
    end
    checks++;
    if (low_n != 96 || low_first != -144 || low_last != -49) begin
      failures++;
      $display("FAIL default_hsync: got %0d cycles sx %0d..%0d, want 96 cycles sx -144..-49",
               low_n, low_first, low_last);
    end
  endtask

  task automatic test_param_frame();
    int f1 = -1, f2 = -1, de_n = 0;
    for (int k = 0; k < 2000 && f2 < 0; k++) begin
      step();
      checks++;
      if (obs1 !== exp1 || frame_cnt1 !== 16'(fc1) || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL param_raster: got %h fc=%0d pend=%b, want %h fc=%0d pend=%b",
                 obs1, frame_cnt1, cfg1.cfg_pending, exp1, fc1, pend1);
      end
      if (frame1) begin
        if (f1 < 0) f1 = k;
        else f2 = k;
      end
      if (f1 >= 0 && f2 < 0 && de1) de_n++;
    end
    checks++;
    if (f1 < 0 || f2 < 0 || f2 - f1 != 680 || de_n != 384) begin
      failures++;
      $display("FAIL param_frame: period=%0d de=%0d, want period=680 de=384", f2 - f1, de_n);
    end
  endtask

  task automatic test_program_small();
    logic [15:0] vals [8] = '{16'd4, 16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd1, 16'd1};
    int n = 0, hs_n = 0, hs_bad = 0, vs_n = 0, vs_bad = 0, fr2 = -1, line_n = 0, de_n = 0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) step();
      step(1'b1, 4'(i), vals[i]);
      checks++;
      if (cfg1.cfg_pending !== 1'b1 || obs1 !== exp1) begin
        failures++;
        $display("FAIL small_write_pending a=%0d: pend=%b vid=%h, want pend=1 vid=%h",
                 i, cfg1.cfg_pending, obs1, exp1);
      end
    end
    while (pend1 && n < 1500) begin
      step();
      n++;
      checks++;
      if (obs1 !== exp1 || frame_cnt1 !== 16'(fc1) || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL small_wait: got %h pend=%b, want %h pend=%b",
                 obs1, cfg1.cfg_pending, exp1, pend1);
      end
    end
    step();
    checks++;
    if (frame1 !== 1'b1 || sx1 !== -16'sd4 || sy1 !== -16'sd3) begin
      failures++;
      $display("FAIL small_first_frame: frame=%b sx=%0d sy=%0d, want 1 -4 -3", frame1, sx1, sy1);
    end
    for (int k = 0; k < 80; k++) begin
      if (k > 0) step();
      checks++;
      if (obs1 !== exp1 || frame_cnt1 !== 16'(fc1) || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL small_raster k=%0d: got %h, want %h", k, obs1, exp1);
      end
      if (hsync1 == 1'b0) begin hs_n++; if (sx1 != -3 && sx1 != -2) hs_bad++; end
      if (vsync1 == 1'b1) begin vs_n++; if (sy1 != -2) vs_bad++; end
      if (k > 0 && frame1 && fr2 < 0) fr2 = k;
      if (line1) line_n++;
      if (de1) de_n++;
    end
    checks++;
    if (fr2 != 40 || line_n != 4 || de_n != 16) begin
      failures++;
      $display("FAIL small_periods: frame=%0d lines=%0d de=%0d, want 40 4 16", fr2, line_n, de_n);
    end
    checks++;
    if (hs_n != 20 || hs_bad != 0 || vs_n != 16 || vs_bad != 0) begin
      failures++;
      $display("FAIL small_syncs: hs=%0d/%0d vs=%0d/%0d, want hs=20/0 vs=16/0",
               hs_n, hs_bad, vs_n, vs_bad);
    end
  endtask

  task automatic test_boundary_write();
    int n = 0, p1 = -1, p2 = -1;
    while (c1 != frame_len(act1) - 1 && n < 200) begin step(); n++; end
    step(1'b1, 4'd3, 16'd2);
    checks++;
    if (cfg1.cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL boundary_pending: got %b, want 1", cfg1.cfg_pending);
    end
    step();
    for (int k = 1; k < 200 && p2 < 0; k++) begin
      step();
      checks++;
      if (obs1 !== exp1 || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL boundary_raster: got %h pend=%b, want %h pend=%b",
                 obs1, cfg1.cfg_pending, exp1, pend1);
      end
      if (frame1) begin
        if (p1 < 0) p1 = k;
        else p2 = k - p1;
      end
    end
    checks++;
    if (p1 != 40 || p2 != 45 || cfg1.cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL boundary_apply: periods %0d,%0d pend=%b, want 40,45 pend=0",
               p1, p2, cfg1.cfg_pending);
    end
    step(1'b1, 4'd3, 16'd1);
    n = 0;
    while (pend1 && n < 200) begin step(); n++; end
    step();
  endtask

  task automatic test_irq();
    int vals [4];
    vals[0] = 1; vals[1] = 5; vals[2] = -1; vals[3] = int'($urandom_range(0, 6)) - 4;
    for (int i = 0; i < 4; i++) begin
      int n = 0, irq_n = 0, irq_sx = 0, irq_sy = 0, want_n;
      step(1'b1, 4'd9, 16'(vals[i]));
      while (pend1 && n < 200) begin step(); n++; end
      for (int k = 0; k < 40; k++) begin
        step();
        checks++;
        if (obs1 !== exp1) begin
          failures++;
          $display("FAIL irq_raster line=%0d: got %h, want %h", vals[i], obs1, exp1);
        end
        if (irq1) begin irq_n++; irq_sx = int'(sx1); irq_sy = int'(sy1); end
      end
      want_n = (vals[i] >= -3 && vals[i] <= 1) ? 1 : 0;
      checks++;
      if (irq_n != want_n || (want_n == 1 && (irq_sx != -4 || irq_sy != vals[i]))) begin
        failures++;
        $display("FAIL irq line=%0d: count=%0d at sx=%0d sy=%0d, want count=%0d at sx=-4 sy=%0d",
                 vals[i], irq_n, irq_sx, irq_sy, want_n, vals[i]);
      end
    end
  endtask

  task automatic test_zero_fields();
    int n = 0, hs_n = 0, mn = 999, mx = -999, fr = -1;
    step(1'b1, 4'd2, 16'd0);
    step(1'b1, 4'd0, 16'd0);
    while (pend1 && n < 200) begin step(); n++; end
    for (int k = 0; k < 30; k++) begin
      step();
      checks++;
      if (obs1 !== exp1) begin
        failures++;
        $display("FAIL zero_raster: got %h, want %h", obs1, exp1);
      end
      if (hsync1 == 1'b0) hs_n++;
      if (int'(sx1) < mn) mn = int'(sx1);
      if (int'(sx1) > mx) mx = int'(sx1);
      if (k > 0 && frame1 && fr < 0) fr = k;
    end
    checks++;
    if (hs_n != 0 || mn != -2 || mx != 0 || fr != 15) begin
      failures++;
      $display("FAIL zero_fields: hs=%0d sx %0d..%0d period=%0d, want hs=0 sx -2..0 period=15",
               hs_n, mn, mx, fr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      logic [3:0] a;
      logic [15:0] d;
      a = 4'($urandom_range(0, 15));
      case (a)
        4'd0, 4'd4: d = 16'($urandom_range(0, 4));
        4'd9:       d = 16'(int'($urandom_range(0, 9)) - 4);
        4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8: d = 16'($urandom_range(0, 3));
        default:    d = 16'($urandom);
      endcase
      step(($urandom_range(0, 5) == 0), a, d);
      checks++;
      if (obs1 !== exp1 || frame_cnt1 !== 16'(fc1) || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL random k=%0d: got %h fc=%0d pend=%b, want %h fc=%0d pend=%b",
                 k, obs1, frame_cnt1, cfg1.cfg_pending, exp1, fc1, pend1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int f1 = -1, f2 = -1;
    step(1'b1, 4'd0, 16'd7);
    repeat (3) step();
    #3 rst = 1'b1;
    reset_models();
    #1;
    checks++;
    if (obs1 !== exp1 || frame_cnt1 !== 16'd0 || cfg1.cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: got %h fc=%0d pend=%b, want %h fc=0 pend=0",
               obs1, frame_cnt1, cfg1.cfg_pending, exp1);
    end
    @(posedge clk_pix);
    #1;
    @(posedge clk_pix);
    #1 rst = 1'b0;
    for (int k = 0; k < 1500 && f2 < 0; k++) begin
      step();
      checks++;
      if (obs1 !== exp1 || frame_cnt1 !== 16'(fc1) || cfg1.cfg_pending !== pend1) begin
        failures++;
        $display("FAIL mid_reset_raster: got %h fc=%0d pend=%b, want %h fc=%0d pend=%b",
                 obs1, frame_cnt1, cfg1.cfg_pending, exp1, fc1, pend1);
      end
      if (frame1) begin
        if (f1 < 0) f1 = k;
        else f2 = k;
      end
    end
    checks++;
    if (f1 != 0 || f2 != 680 || frame_cnt1 !== 16'd2) begin
      failures++;
      $display("FAIL mid_reset_defaults: first=%0d second=%0d fc=%0d, want 0 680 2",
               f1, f2, frame_cnt1);
    end
  endtask

  initial begin
    def0 = '{hres: 640, hfp: 16, hs: 96, hbp: 48, vres: 480, vfp: 10, vs: 2, vbp: 33,
             hpol: 0, vpol: 0, irq: 0};
    def1 = '{hres: 32, hfp: 2, hs: 4, hbp: 2, vres: 12, vfp: 1, vs: 2, vbp: 2,
             hpol: 0, vpol: 1, irq: 3};
    test_reset();
    test_default_mode();
    test_param_frame();
    test_program_small();
    test_boundary_write();
    test_irq();
    test_zero_fields();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdu_timing_gen.md
# vdu_timing_gen

Runtime-programmable video timing generator for the VDU, producing syncs, data enable, frame/line strobes and signed screen coordinates from the pixel clock. Parameters supply only the power-up mode; every timing field can be rewritten over a small config port. Writes land in shadow registers and take effect atomically at the next frame boundary. It also provides a raster-line interrupt strobe and a frame counter, and drives the VDU pixel pipeline and the video PHY.

## Interface
- CORDW, 16, signed coordinate / config field width (bits)
- FCW, 16, frame counter width
- H_RES, 640, power-up horizontal active pixels
- V_RES, 480, power-up vertical active lines
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, power-up horizontal porches and sync
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, power-up vertical porches and sync
- H_POL / V_POL, 0 / 0, power-up sync polarity (0 neg, 1 pos)
- IRQ_LINE, 0, power-up raster interrupt line (signed)

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst  in  1  reset; asynchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  0 h_res, 1 h_fp, 2 h_sync, 3 h_bp, 4 v_res, 5 v_fp, 6 v_sync, 7 v_bp, 8 pol ({v_pol,h_pol} in bits 1:0), 9 irq_line; 10-15 ignored
- cfg_wdata  in  CORDW  config write data
- cfg_pending  out  1  shadow differs from active set (a write awaits the frame boundary)
- hsync, vsync  out  1  syncs at the programmed polarity
- de  out  1  high in active area
- frame  out  1  one-cycle strobe at the first blanking pixel of a frame
- line  out  1  one-cycle strobe at the start of each line with sy >= 0
- irq  out  1  one-cycle strobe at the start of line irq_line
- sx, sy  out  CORDW signed  screen position
- frame_cnt  out  FCW  frames started since reset, wrapping

## Operation
- Active set per axis: RES, FP, SYNC, BP, plus POL. Derived values:
  - STA = -(FP+SYNC+BP)
  - SS = STA+FP (sync start)
  - SE = SS+SYNC (sync end)
  - active range 0..RES-1
- Internal counters x, y. x counts STA..h_res-1 and then wraps to STA. When x wraps, y increments, or wraps from v_res-1 to STA.
- Frame boundary is the edge on which x==h_res-1 and y==v_res-1. On that edge:
  - shadow is copied to active;
  - x and y load the new STAs, not the old ones;
  - cfg_pending clears.
- cfg_we writes shadow[cfg_addr] on the clock edge. A write on the frame-boundary edge is not part of that transfer; it stays pending for the next frame.
- A write of 0 to h_res or v_res is stored as 1. Porch/sync fields are treated as unsigned, and 0 is legal. h_sync=0 means hsync never asserts.
- Sum of FP+SYNC+BP per axis must be below 2^(CORDW-1); this is not checked.
- Registered outputs are computed from the same x, y, all in the same cycle, so they are mutually aligned:
  - sx=x, sy=y;
  - de = x>=0 && y>=0;
  - hsync active while SS <= x < SE (exactly h_sync cycles);
  - vsync active while SS <= y < SE (whole lines);
  - frame = (x==h STA && y==v STA);
  - line = (x==h STA && y>=0);
  - irq = (x==h STA && y==irq_line), signed compare. An out-of-range irq_line never fires.
  - frame_cnt increments on the edge frame is registered high.
- Reset (async, any time, including mid-frame):
  - shadow and active load the parameters; pending writes are discarded;
  - x=sx=h STA, y=sy=v STA;
  - hsync/vsync at their inactive level per the parameter polarity;
  - de=frame=line=irq=0, frame_cnt=0, cfg_pending=0.

## Timing
- Outputs are registered with 1-cycle latency from x, y. The first edge after rst deasserts produces frame=1 with sx=h STA, sy=v STA.
- Line period is h_res+h_fp+h_sync+h_bp cycles. Frame period is line period × (v_res+v_fp+v_sync+v_bp).
- A config write becomes visible at the first frame strobe after the next frame boundary. Latency is therefore 1 cycle to 1 frame + 1 cycle.
- Polarity changes also wait for the frame boundary; there is no sync glitch mid-frame.
- cfg_pending goes high on the edge after any cfg_we to addresses 0-9. It goes low on the boundary edge unless a write occurs on that same edge.

## Test plan
- Power-up 640x480 defaults, release reset:
  - frame=1 for one cycle with sx=-160, sy=-45;
  - line period 800 cycles, frame period 420000;
  - hsync low for exactly 96 cycles per line (sx -144..-49);
  - de high for 640×480 cycles per frame.
- Program h_res=4, h_fp=1, h_sync=2, h_bp=1, v_res=2, v_fp=1, v_sync=1, v_bp=1:
  - cfg_pending=1 until the boundary;
  - next frame has 8-cycle lines, sx -4..3, hsync active at sx=-3,-2;
  - 40-cycle frames, vsync on sy=-2.
- Write on exactly the frame-boundary edge: the value is not applied this frame, cfg_pending stays 1, and it is applied one frame later.
- irq_line=1 on the small mode: irq pulses once per frame with sy=1, sx=-4. irq_line=5 gives no irq. irq_line=-1 fires in blanking.
- Assert rst mid-line on the small mode with a pending write:
  - outputs go to reset values immediately (async);
  - after release, timings equal the parameter defaults and frame_cnt=0.
- h_sync=0 and h_res written 0: hsync never asserts and h_res is stored as 1 (sx -2..0 with fp=bp=1).
